// File: rtl/copr_pkg.sv
// Shared types for the coprocessor datapath front end.
// Holds the front-end FSM encoding and the skid buffer depth.
package copr_pkg;

    typedef enum logic [1:0] {
        FE_IDLE = 2'd0,
        FE_RUN  = 2'd1,
        FE_FIN  = 2'd2
    } fe_state_e;

    localparam int FE_BUF_DEPTH = 2;

endpackage

// File: rtl/copr_front_end_if.sv
// Word stream from the front end to the actor network.
// A word moves when send and rdy are both high.
interface copr_front_end_if #(
    parameter int SIZEDATA = 32
);
    logic [SIZEDATA-1:0] data;
    logic                send;
    logic                rdy;

    modport master (output data, output send, input rdy);
    modport slave  (input data, input send, output rdy);
endinterface

// File: rtl/copr_skid_fifo.sv
// Two-entry FIFO absorbing read data while the stream is stalled.
// Flushed by reset or clear.
module copr_skid_fifo
    import copr_pkg::*;
#(
    parameter int SIZEDATA = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                push,
    input  logic                pop,
    input  logic [SIZEDATA-1:0] din,
    output logic [SIZEDATA-1:0] dout,
    output logic [1:0]          fill,
    output logic                full,
    output logic                empty
);

    logic [SIZEDATA-1:0] mem [FE_BUF_DEPTH];
    logic                wp;
    logic                rp;

    assign dout  = mem[rp];
    assign full  = (fill == 2'd2);
    assign empty = (fill == 2'd0);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wp   <= 1'b0;
            rp   <= 1'b0;
            fill <= 2'd0;
        end else begin
            if (push) begin
                mem[wp] <= din;
                wp      <= ~wp;
            end
            if (pop) begin
                rp <= ~rp;
            end
            unique case ({push, pop})
                2'b10:   fill <= fill + 2'd1;
                2'b01:   fill <= fill - 2'd1;
                default: fill <= fill;
            endcase
        end
    end

    a_no_overflow: assert property (
        @(posedge clk) disable iff (reset || clear)
        !(push && full && !pop)
    );

    a_no_underflow: assert property (
        @(posedge clk) disable iff (reset || clear)
        !(pop && empty)
    );

endmodule

// File: rtl/copr_front_end.sv
// Coprocessor input stage: streams SIZE words of local memory from BASE.
// COPR_FE_STRIDE_EN adds a stride port that sets the address step.
module copr_front_end
    import copr_pkg::*;
#(
    parameter int SIZEDATA  = 32,
    parameter int SIZEADDR  = 12,
    parameter int SIZECOUNT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 clear,
    input  logic [SIZEADDR-1:0]  base_addr,
    input  logic [SIZECOUNT-1:0] size,
`ifdef COPR_FE_STRIDE_EN
    input  logic [SIZEADDR-1:0]  stride,
`endif
    output logic                 mem_en,
    output logic [SIZEADDR-1:0]  mem_addr,
    input  logic [SIZEDATA-1:0]  mem_data,
    copr_front_end_if.master     out,
    output logic                 busy,
    output logic                 done
);

    fe_state_e state, state_n;

    logic [SIZEADDR-1:0]  addr;
    logic [SIZEADDR-1:0]  step;
    logic [SIZECOUNT-1:0] size_q;
    logic [SIZECOUNT-1:0] issued;
    logic [SIZECOUNT-1:0] accepted;
    logic                 rd_valid;
    logic [1:0]           fill;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [SIZEDATA-1:0]  fifo_dout;
    logic                 take;
    logic                 xfer;
    logic                 push;
    logic                 pop;
    logic                 last;

`ifndef COPR_FE_STRIDE_EN
    assign step = SIZEADDR'(1);
`endif

    assign take = start && (state == FE_IDLE);

    // Credit: buffered words plus reads in flight never exceed the buffer.
    assign mem_en = (state == FE_RUN)
                 && (issued < size_q)
                 && !fifo_full
                 && ((int'(fill) + int'(rd_valid)) < FE_BUF_DEPTH);
    assign mem_addr = addr;

    // An empty buffer lets fresh read data go straight out.
    assign out.send = !fifo_empty || rd_valid;
    assign out.data = fifo_empty ? mem_data : fifo_dout;

    assign xfer = out.send && out.rdy;
    assign pop  = xfer && !fifo_empty;
    assign push = rd_valid && !(fifo_empty && xfer);
    assign last = xfer && (accepted == size_q - SIZECOUNT'(1));

    assign busy = (state == FE_RUN);
    assign done = (state == FE_FIN);

    copr_skid_fifo #(
        .SIZEDATA (SIZEDATA)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .push  (push),
        .pop   (pop),
        .din   (mem_data),
        .dout  (fifo_dout),
        .fill  (fill),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_n = state;
        unique case (state)
            FE_IDLE: begin
                if (start) begin
                    state_n = (size == '0) ? FE_FIN : FE_RUN;
                end
            end
            FE_RUN: begin
                if (last) begin
                    state_n = FE_FIN;
                end
            end
            FE_FIN:  state_n = FE_IDLE;
            default: state_n = FE_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state    <= FE_IDLE;
            addr     <= '0;
            size_q   <= '0;
            issued   <= '0;
            accepted <= '0;
            rd_valid <= 1'b0;
`ifdef COPR_FE_STRIDE_EN
            step     <= '0;
`endif
        end else begin
            state    <= state_n;
            rd_valid <= mem_en;
            if (take) begin
                addr     <= base_addr;
                size_q   <= size;
                issued   <= '0;
                accepted <= '0;
`ifdef COPR_FE_STRIDE_EN
                step     <= stride;
`endif
            end else begin
                if (mem_en) begin
                    addr   <= addr + step;
                    issued <= issued + SIZECOUNT'(1);
                end
                if (xfer) begin
                    accepted <= accepted + SIZECOUNT'(1);
                end
            end
        end
    end

endmodule
